// File: rtl/lieat_clint_pkg.sv
// lieat_clint_pkg: shared constants for the multi-hart CLINT.
//   - address offsets of the msip, mtimecmp and mtime registers
//   - per-hart address strides
//   - reset value of every mtimecmp register
//   - helpers that turn a hart index into its register offset
package lieat_clint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    localparam int MSIP_STRIDE     = 4;
    localparam int MTIMECMP_STRIDE = 8;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [15:0] msip_addr(input int h);
        return MSIP_BASE + 16'(MSIP_STRIDE * h);
    endfunction

    function automatic logic [15:0] mtimecmp_lo_addr(input int h);
        return MTIMECMP_BASE + 16'(MTIMECMP_STRIDE * h);
    endfunction

    function automatic logic [15:0] mtimecmp_hi_addr(input int h);
        return MTIMECMP_BASE + 16'(MTIMECMP_STRIDE * h + 4);
    endfunction

endpackage

// File: rtl/lieat_clint_hart.sv
// lieat_clint_hart: per-hart state of the CLINT.
//   Holds the msip bit, the two mtimecmp halves and the registered
//   timer compare.
//   Ports: clock, reset; msip_we / cmp_lo_we / cmp_hi_we write strobes
//   with shared wdata; mtime (shared timebase); msip, mtimecmp and mtip
//   outputs.
module lieat_clint_hart
    import lieat_clint_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        msip_we,
    input  logic        cmp_lo_we,
    input  logic        cmp_hi_we,
    input  logic [31:0] wdata,
    input  logic [63:0] mtime,
    output logic        msip,
    output logic [63:0] mtimecmp,
    output logic        mtip
);
    logic [31:0] cmp_lo_q;
    logic [31:0] cmp_hi_q;
    logic        mtip_nxt;

    // Only bit 0 of a msip write is architecturally meaningful.
    lieat_general_dfflr #(.DW(1)) u_msip (
        .clock (clock), .reset (reset), .lden (msip_we),
        .dnxt  (wdata[0]), .qout (msip)
    );

    // Both halves reset to all ones so no timer interrupt fires after reset.
    lieat_general_dfflrs #(.DW(32)) u_cmp_lo (
        .clock (clock), .reset (reset), .lden (cmp_lo_we),
        .dnxt  (wdata), .qout (cmp_lo_q)
    );

    lieat_general_dfflrs #(.DW(32)) u_cmp_hi (
        .clock (clock), .reset (reset), .lden (cmp_hi_we),
        .dnxt  (wdata), .qout (cmp_hi_q)
    );

    assign mtimecmp = {cmp_hi_q, cmp_lo_q};

    // Compare on current register values; the result lands one cycle later.
    assign mtip_nxt = (mtime >= mtimecmp);

    lieat_general_dfflr #(.DW(1)) u_mtip (
        .clock (clock), .reset (reset), .lden (1'b1),
        .dnxt  (mtip_nxt), .qout (mtip)
    );
endmodule

// File: rtl/lieat_general_dff.sv
// lieat_general_dfflr / lieat_general_dfflrs: load-enabled flops with
// asynchronous active-high reset.
//   dfflr  resets to all zeros, dfflrs resets to all ones.
//   Ports: clock, reset, lden (load enable), dnxt (next value), qout.
module lieat_general_dfflr #(
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end
endmodule

module lieat_general_dfflrs #(
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            qout <= '1;
        end else if (lden) begin
            qout <= dnxt;
        end
    end
endmodule

// File: rtl/lieat_clint_mh.sv
// lieat_clint_mh: multi-hart core-local interruptor.
//   Shared 64-bit mtime with a prescaler, per-hart msip/mtimecmp/mtip.
//   Ports: clock, reset (async, active high); tick_en timebase enable;
//   bus_ren/bus_wen/bus_addr/bus_wdata MMIO request; bus_rdata/bus_rvalid
//   registered read response; bus_err unmapped-access flag; mtip/msip
//   per-hart interrupts.
// Bus handshake: a request is accepted in the cycle bus_ren or bus_wen is
// high (no backpressure); bus_rvalid pulses exactly one cycle after
// bus_ren, and bus_err pulses in that same response cycle (or one cycle
// after bus_wen) when the address is unmapped.
module lieat_clint_mh
    import lieat_clint_pkg::*;
#(
    parameter int HART_NUM = 2,
    parameter int TICK_DIV = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick_en,
    input  logic                bus_ren,
    input  logic                bus_wen,
    input  logic [15:0]         bus_addr,
    input  logic [31:0]         bus_wdata,
    output logic [31:0]         bus_rdata,
    output logic                bus_rvalid,
    output logic                bus_err,
    output logic [HART_NUM-1:0] mtip,
    output logic [HART_NUM-1:0] msip
);
    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    logic [15:0]         addr_w;
    logic [HART_NUM-1:0] msip_sel;
    logic [HART_NUM-1:0] cmp_lo_sel;
    logic [HART_NUM-1:0] cmp_hi_sel;
    logic                mtime_lo_sel;
    logic                mtime_hi_sel;
    logic                mapped;
    logic [63:0]         cmp_val [HART_NUM];
    logic [31:0]         rdata_nxt;

    logic [15:0] presc_q;
    logic [15:0] presc_nxt;
    logic        presc_wrap;
    logic        tick;
    logic [63:0] mtime_q;
    logic [63:0] mtime_nxt;
    logic        mtime_lo_we;
    logic        mtime_hi_we;
    logic        err_nxt;

    // ---------------- prescaler and mtime ----------------
    assign presc_wrap = (presc_q == PRESC_MAX);
    assign presc_nxt  = presc_wrap ? 16'd0 : presc_q + 16'd1;
    assign tick       = tick_en & presc_wrap;

    lieat_general_dfflr #(.DW(16)) u_presc (
        .clock (clock), .reset (reset), .lden (tick_en),
        .dnxt  (presc_nxt), .qout (presc_q)
    );

    assign mtime_lo_we = bus_wen & mtime_lo_sel;
    assign mtime_hi_we = bus_wen & mtime_hi_sel;

    // A software write to either half suppresses the whole 64-bit increment.
    always_comb begin
        mtime_nxt = mtime_q + 64'd1;
        if (mtime_lo_we) begin
            mtime_nxt = {mtime_q[63:32], bus_wdata};
        end else if (mtime_hi_we) begin
            mtime_nxt = {bus_wdata, mtime_q[31:0]};
        end
    end

    lieat_general_dfflr #(.DW(64)) u_mtime (
        .clock (clock), .reset (reset),
        .lden  (mtime_lo_we | mtime_hi_we | tick),
        .dnxt  (mtime_nxt), .qout (mtime_q)
    );

    // ---------------- address decode ----------------
    assign addr_w = bus_addr & 16'hFFFC;

    always_comb begin
        msip_sel   = '0;
        cmp_lo_sel = '0;
        cmp_hi_sel = '0;
        for (int h = 0; h < HART_NUM; h++) begin
            msip_sel[h]   = (addr_w == msip_addr(h));
            cmp_lo_sel[h] = (addr_w == mtimecmp_lo_addr(h));
            cmp_hi_sel[h] = (addr_w == mtimecmp_hi_addr(h));
        end
    end

    assign mtime_lo_sel = (addr_w == MTIME_LO);
    assign mtime_hi_sel = (addr_w == MTIME_HI);
    assign mapped = (|msip_sel) | (|cmp_lo_sel) | (|cmp_hi_sel)
                  | mtime_lo_sel | mtime_hi_sel;

    // ---------------- harts ----------------
    for (genvar h = 0; h < HART_NUM; h++) begin : g_hart
        lieat_clint_hart u_hart (
            .clock     (clock),
            .reset     (reset),
            .msip_we   (bus_wen & msip_sel[h]),
            .cmp_lo_we (bus_wen & cmp_lo_sel[h]),
            .cmp_hi_we (bus_wen & cmp_hi_sel[h]),
            .wdata     (bus_wdata),
            .mtime     (mtime_q),
            .msip      (msip[h]),
            .mtimecmp  (cmp_val[h]),
            .mtip      (mtip[h])
        );
    end

    // ---------------- read mux and response ----------------
    // Unmapped offsets leave rdata_nxt at zero. Register values are taken
    // before any same-cycle write lands, so read-during-write sees old data.
    always_comb begin
        rdata_nxt = '0;
        for (int h = 0; h < HART_NUM; h++) begin
            if (msip_sel[h])   rdata_nxt = {31'b0, msip[h]};
            if (cmp_lo_sel[h]) rdata_nxt = cmp_val[h][31:0];
            if (cmp_hi_sel[h]) rdata_nxt = cmp_val[h][63:32];
        end
        if (mtime_lo_sel) rdata_nxt = mtime_q[31:0];
        if (mtime_hi_sel) rdata_nxt = mtime_q[63:32];
    end

    assign err_nxt = (bus_ren | bus_wen) & ~mapped;

    lieat_general_dfflr #(.DW(1)) u_rvalid (
        .clock (clock), .reset (reset), .lden (1'b1),
        .dnxt  (bus_ren), .qout (bus_rvalid)
    );

    // Loads only on a read so the data holds between responses.
    lieat_general_dfflr #(.DW(32)) u_rdata (
        .clock (clock), .reset (reset), .lden (bus_ren),
        .dnxt  (rdata_nxt), .qout (bus_rdata)
    );

    lieat_general_dfflr #(.DW(1)) u_err (
        .clock (clock), .reset (reset), .lden (1'b1),
        .dnxt  (err_nxt), .qout (bus_err)
    );
endmodule

// File: tb/tb_lieat_clint_mh.sv
module tb_lieat_clint_mh;
  localparam int HN = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          tick_en = 1'b0;
  logic          tick_en4 = 1'b0;
  logic          bus_ren = 1'b0;
  logic          bus_ren4 = 1'b0;
  logic          bus_wen = 1'b0;
  logic          bus_wen4 = 1'b0;
  logic [15:0]   bus_addr = '0;
  logic [31:0]   bus_wdata = '0;
  logic [31:0]   bus_rdata, bus_rdata4;
  logic          bus_rvalid, bus_rvalid4;
  logic          bus_err, bus_err4;
  logic [HN-1:0] mtip, msip, mtip4, msip4;

  lieat_clint_mh #(.HART_NUM(HN), .TICK_DIV(1)) dut (
    .clock(clock), .reset(reset), .tick_en(tick_en),
    .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .bus_err(bus_err), .mtip(mtip), .msip(msip)
  );

  lieat_clint_mh #(.HART_NUM(HN), .TICK_DIV(4)) dut4 (
    .clock(clock), .reset(reset), .tick_en(tick_en4),
    .bus_ren(bus_ren4), .bus_wen(bus_wen4), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata4), .bus_rvalid(bus_rvalid4),
    .bus_err(bus_err4), .mtip(mtip4), .msip(msip4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic do_read(input bit use4, input logic [15:0] addr,
                         input logic [31:0] exp_data, input logic exp_err, input string name);
    bus_addr = addr;
    if (use4) bus_ren4 = 1'b1; else bus_ren = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus_ren = 1'b0;
    bus_ren4 = 1'b0;
    if (use4) begin
      check({name, "_rvalid"}, 64'(bus_rvalid4), 64'd1);
      check({name, "_rdata"}, 64'(bus_rdata4), 64'(exp_data));
      check({name, "_err"}, 64'(bus_err4), 64'(exp_err));
    end else begin
      check({name, "_rvalid"}, 64'(bus_rvalid), 64'd1);
      check({name, "_rdata"}, 64'(bus_rdata), 64'(exp_data));
      check({name, "_err"}, 64'(bus_err), 64'(exp_err));
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                          input logic exp_err, input string name);
    bus_addr = addr;
    bus_wdata = data;
    bus_wen = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus_wen = 1'b0;
    check({name, "_err"}, 64'(bus_err), 64'(exp_err));
    check({name, "_rvalid"}, 64'(bus_rvalid), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [1:0]  exp_msip;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b1, 16'h0004, 32'hFFFF_FFFF, 32'h0,         1'b0, 2'b10};
    vecs[1]  = '{1'b0, 16'h0004, 32'h0,         32'h1,         1'b0, 2'b10};
    vecs[2]  = '{1'b0, 16'h0000, 32'h0,         32'h0,         1'b0, 2'b10};
    vecs[3]  = '{1'b1, 16'h0008, 32'h1,         32'h0,         1'b1, 2'b10};
    vecs[4]  = '{1'b0, 16'h0008, 32'h0,         32'h0,         1'b1, 2'b10};
    vecs[5]  = '{1'b0, 16'h8000, 32'h0,         32'h0,         1'b1, 2'b10};
    vecs[6]  = '{1'b1, 16'h4000, 32'h1234_5678, 32'h0,         1'b0, 2'b10};
    vecs[7]  = '{1'b0, 16'h4000, 32'h0,         32'h1234_5678, 1'b0, 2'b10};
    vecs[8]  = '{1'b0, 16'h4004, 32'h0,         32'hFFFF_FFFF, 1'b0, 2'b10};
    vecs[9]  = '{1'b0, 16'h400C, 32'h0,         32'hFFFF_FFFF, 1'b0, 2'b10};
    vecs[10] = '{1'b1, 16'h4010, 32'h5,         32'h0,         1'b1, 2'b10};
    vecs[11] = '{1'b0, 16'h4010, 32'h0,         32'h0,         1'b1, 2'b10};
    vecs[12] = '{1'b0, 16'h0006, 32'h0,         32'h1,         1'b0, 2'b10};
    vecs[13] = '{1'b1, 16'h0004, 32'hFFFF_FFFE, 32'h0,         1'b0, 2'b00};
    vecs[14] = '{1'b1, 16'h0000, 32'h0000_0001, 32'h0,         1'b0, 2'b01};
    vecs[15] = '{1'b0, 16'h0000, 32'h0,         32'h1,         1'b0, 2'b01};
  end

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(negedge clock);
    check("rst_rdata", 64'(bus_rdata), 64'd0);
    check("rst_rvalid", 64'(bus_rvalid), 64'd0);
    check("rst_err", 64'(bus_err), 64'd0);
    check("rst_mtip", 64'(mtip), 64'd0);
    check("rst_msip", 64'(msip), 64'd0);

    // Timebase counts every cycle with TICK_DIV=1.
    tick_en = 1'b1;
    reset = 1'b0;
    do_read(1'b0, 16'hBFF8, 32'd0, 1'b0, "t1_lo0");
    do_read(1'b0, 16'hBFFC, 32'd0, 1'b0, "t1_hi0");
    repeat (8) @(negedge clock);
    do_read(1'b0, 16'hBFF8, 32'd10, 1'b0, "t1_lo10");
    check("t1_mtip", 64'(mtip), 64'd0);
    tick_en = 1'b0;

    // Register map / unmapped accesses from the table.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_err, $sformatf("vec%0d_w", i));
      else
        do_read(1'b0, vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d_r", i));
      check($sformatf("vec%0d_msip", i), 64'(msip), 64'(vecs[i].exp_msip));
      check($sformatf("vec%0d_mtip", i), 64'(mtip), 64'd0);
    end

    // Prescaler TICK_DIV=4: 12 enabled cycles give 3 ticks, then hold.
    tick_en4 = 1'b1;
    repeat (12) @(negedge clock);
    tick_en4 = 1'b0;
    do_read(1'b1, 16'hBFF8, 32'd3, 1'b0, "t2_hold_a");
    repeat (7) @(negedge clock);
    do_read(1'b1, 16'hBFF8, 32'd3, 1'b0, "t2_hold_b");
    tick_en4 = 1'b1;
    repeat (3) @(negedge clock);
    do_read(1'b1, 16'hBFF8, 32'd3, 1'b0, "t2_resume3");
    tick_en4 = 1'b0;
    do_read(1'b1, 16'hBFF8, 32'd4, 1'b0, "t2_resume4");

    // Carry lo->hi, with write-wins over the running timebase.
    tick_en = 1'b1;
    do_write(16'hBFF8, 32'hFFFF_FFFE, 1'b0, "t3_wlo");
    do_write(16'hBFFC, 32'h0, 1'b0, "t3_whi");
    repeat (2) @(negedge clock);
    do_read(1'b0, 16'hBFFC, 32'h1, 1'b0, "t3_hi");
    do_read(1'b0, 16'hBFF8, 32'h1, 1'b0, "t3_lo");
    tick_en = 1'b0;

    // Full 64-bit wrap.
    do_write(16'hBFFC, 32'hFFFF_FFFF, 1'b0, "wrap_whi");
    do_write(16'hBFF8, 32'hFFFF_FFFE, 1'b0, "wrap_wlo");
    tick_en = 1'b1;
    do_read(1'b0, 16'hBFF8, 32'hFFFF_FFFE, 1'b0, "wrap_lo_a");
    do_read(1'b0, 16'hBFF8, 32'hFFFF_FFFF, 1'b0, "wrap_lo_b");
    do_read(1'b0, 16'hBFFC, 32'h0, 1'b0, "wrap_hi");
    tick_en = 1'b0;

    // mtip[1]: mtime 15 -> 20 against mtimecmp[1]=20.
    do_write(16'hBFFC, 32'd0, 1'b0, "t4_whi");
    do_write(16'hBFF8, 32'd15, 1'b0, "t4_wlo");
    do_write(16'h4008, 32'd20, 1'b0, "t4_cmplo");
    do_write(16'h400C, 32'd0, 1'b0, "t4_cmphi");
    check("t4_pre_mtip", 64'(mtip), 64'd0);
    tick_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      check($sformatf("t4_mtip1_c%0d", i), 64'(mtip[1]), (i >= 6) ? 64'd1 : 64'd0);
      check($sformatf("t4_mtip0_c%0d", i), 64'(mtip[0]), 64'd0);
    end

    // Raising mtimecmp[1] drops mtip[1] one cycle after the write.
    do_write(16'h400C, 32'd1, 1'b0, "t5_cmphi");
    check("t5_mtip_same", 64'(mtip[1]), 64'd1);
    @(negedge clock);
    check("t5_mtip_fall", 64'(mtip[1]), 64'd0);

    // Reset in the middle of a read drops the pending response.
    bus_addr = 16'hBFF8;
    bus_ren = 1'b1;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_rvalid", 64'(bus_rvalid), 64'd0);
    check("mid_rst_rdata", 64'(bus_rdata), 64'd0);
    check("mid_rst_msip", 64'(msip), 64'd0);
    check("mid_rst_mtip", 64'(mtip), 64'd0);
    @(negedge clock);
    bus_ren = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    do_read(1'b0, 16'hBFF8, 32'd0, 1'b0, "post_rst_mtime");
    do_read(1'b0, 16'h400C, 32'hFFFF_FFFF, 1'b0, "post_rst_cmp1hi");
    do_read(1'b0, 16'h0000, 32'd0, 1'b0, "post_rst_msip0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
